hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Parametrised pipeline hazard controller for the 5-stage core, sitting between the IF/ID and ID/EX registers and driving PC, IF/ID and ID/EX write/flush controls. It extends single-cycle load-use detection with a configurable load latency (multi-bubble stalls held by a small FSM), x0 and unused-operand filtering, and taken-branch flush. It also adds a data-memory wait freeze and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- LOAD_LATENCY, 1, bubbles inserted per load-use hazard (1..15)
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-high; one clock, reset asynchronous active-high
- if_id_rs1  input  REG_ADDR_W  source 1 of instruction in ID
- if_id_rs2  input  REG_ADDR_W  source 2 of instruction in ID
- if_id_uses_rs1  input  1  ID instruction reads rs1
- if_id_uses_rs2  input  1  ID instruction reads rs2
- id_ex_rd  input  REG_ADDR_W  destination of instruction in EX
- MemRead  input  1  EX instruction is a load
- branch_taken  input  1  EX resolved a taken branch/jump
- mem_busy  input  1  data memory not ready; whole pipeline must hold
- PC_Write  output  1  PC enable
- If_id_write  output  1  IF/ID enable
- if_id_flush  output  1  zero IF/ID contents
- muxcontrolbit  output  1  1 = pass ID controls to ID/EX, 0 = insert bubble
- pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB
- stall_count  output  CNT_W  cycles with PC_Write=0, saturating

## Operation
- hazard = MemRead & (id_ex_rd != 0) & ((if_id_uses_rs1 & rs1==id_ex_rd) | (if_id_uses_rs2 & rs2==id_ex_rd)).
- FSM states: RUN, LOAD_WAIT. Counter wait_cnt (4 bits).
- Priority per cycle: mem_busy > branch_taken > (LOAD_WAIT or hazard) > normal.
- mem_busy=1: PC_Write=0, If_id_write=0, muxcontrolbit=1, pipe_freeze=1, if_id_flush=0; state and wait_cnt hold.
- branch_taken=1 (mem_busy=0): PC_Write=1, If_id_write=1, if_id_flush=1, muxcontrolbit=0; FSM forced to RUN, wait_cnt cleared (wrong-path stall cancelled).
- RUN & hazard: PC_Write=0, If_id_write=0, muxcontrolbit=0. If LOAD_LATENCY>1: next state LOAD_WAIT, wait_cnt=LOAD_LATENCY-1; else stay RUN.
- LOAD_WAIT: same stall outputs regardless of inputs; wait_cnt decrements; at wait_cnt==1 next state RUN.
- Normal: PC_Write=1, If_id_write=1, muxcontrolbit=1, flush=0, freeze=0.
- stall_count increments every cycle PC_Write=0 (includes mem_busy cycles); holds at 2^CNT_W-1.

## Timing
- All control outputs combinational from inputs and current state; zero-cycle detection latency.
- A load-use hazard yields exactly LOAD_LATENCY consecutive bubble cycles, excluding mem_busy cycles interleaved.
- stall_count updates on the edge ending the stalled cycle.
- Reset values (asynchronous): state=RUN, wait_cnt=0, stall_count=0; outputs thus PC_Write=1, If_id_write=1, muxcontrolbit=1, if_id_flush=0, pipe_freeze=0 (given idle inputs).
- Reset mid-LOAD_WAIT aborts the stall immediately.
- rd==x0 load never stalls; unused operand with matching address never stalls.

## Structure
- Shared package hazard_pkg: state encoding (RUN, LOAD_WAIT), wait counter width constant, LOAD_LATENCY legal-range check.
- One sub-module: sat_counter (parameter W; inc, clear-on-reset, saturate) instantiated for stall_count.

## Test plan
- LOAD_LATENCY=1, MemRead=1, id_ex_rd=5, rs1=5 uses_rs1=1 -> one cycle PC_Write=0, muxcontrolbit=0; stall_count=1.
- LOAD_LATENCY=3, same hazard, MemRead drops next cycle -> three stall cycles, then RUN; stall_count=3.
- id_ex_rd=0 with rs1=0, or rs2 match with uses_rs2=0 -> no stall, stall_count stays 0.
- LOAD_LATENCY=3, branch_taken in second stall cycle -> that cycle if_id_flush=1, muxcontrolbit=0, PC_Write=1; next cycle normal.
- LOAD_LATENCY=2 hazard, mem_busy=1 for 2 cycles after first bubble -> freeze 2 cycles (pipe_freeze=1, muxcontrolbit=1), then 1 remaining bubble; stall_count=4.
- CNT_W=4, 20 mem_busy cycles -> stall_count saturates at 15; reset asserted during LOAD_WAIT -> outputs normal and count 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// load-wait counter sizing and the legal load-latency range.
package hazard_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // Width of the remaining-bubble counter; bounds the largest load latency.
  localparam int WAIT_W           = 4;
  localparam int MAX_LOAD_LATENCY = (1 << WAIT_W) - 1;

  // A load latency must insert at least one bubble and fit the wait counter.
  function automatic bit latency_ok(input int lat);
    return (lat >= 1) && (lat <= MAX_LOAD_LATENCY);
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count requested cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls of configurable length,
// taken-branch flush, data-memory freeze and a stall-cycle counter.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_uses_rs1,
  input  logic                  if_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  MemRead,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  PC_Write,
  output logic                  If_id_write,
  output logic                  if_id_flush,
  output logic                  muxcontrolbit,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      stall_count
);

  if (!latency_ok(LOAD_LATENCY)) begin : g_bad_latency
    $fatal(1, "hazard_control_unit: LOAD_LATENCY out of range");
  end

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hazard;
  logic              rs1_hit;
  logic              rs2_hit;

  // Only operands the ID instruction actually reads can collide, and x0 never does.
  assign rs1_hit = if_id_uses_rs1 && (if_id_rs1 == id_ex_rd);
  assign rs2_hit = if_id_uses_rs2 && (if_id_rs2 == id_ex_rd);
  assign hazard  = MemRead && (id_ex_rd != '0) && (rs1_hit || rs2_hit);

  // Control outputs are combinational so a hazard stalls in the cycle it is seen.
  always_comb begin
    PC_Write      = 1'b1;
    If_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    muxcontrolbit = 1'b1;
    pipe_freeze   = 1'b0;
    if (mem_busy) begin
      // Whole pipeline holds; ID/EX keeps its contents rather than taking a bubble.
      PC_Write    = 1'b0;
      If_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_taken) begin
      // Wrong-path fetch and decode are discarded.
      if_id_flush   = 1'b1;
      muxcontrolbit = 1'b0;
    end else if ((state == LOAD_WAIT) || hazard) begin
      PC_Write      = 1'b0;
      If_id_write   = 1'b0;
      muxcontrolbit = 1'b0;
    end
  end

  // Track bubbles still owed to an in-flight load; memory wait pauses the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else if (mem_busy) begin
      state    <= state;
      wait_cnt <= wait_cnt;
    end else if (branch_taken) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else if (state == LOAD_WAIT) begin
      wait_cnt <= wait_cnt - WAIT_W'(1);
      if (wait_cnt == WAIT_W'(1))
        state <= RUN;
    end else if (hazard && (LOAD_LATENCY > 1)) begin
      state    <= LOAD_WAIT;
      wait_cnt <= WAIT_W'(LOAD_LATENCY - 1);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (~PC_Write),
    .count (stall_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: four instances (latency 1/2/3, and a
// 4-bit-counter variant) share stimulus and are checked against a
// bubbles-owed reference model, a vector table and directed sequences.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, busy;

  logic        o_pcw [4];
  logic        o_ifw [4];
  logic        o_fl  [4];
  logic        o_mux [4];
  logic        o_frz [4];
  logic [15:0] sc    [4];

  int checks = 0;
  int errors = 0;

  // Reference model: bubbles still owed after the current one, and stall total.
  int rem  [4];
  int mcnt [4];
  int mlat [4] = '{1, 2, 3, 3};
  int mmax [4] = '{65535, 65535, 65535, 15};

  localparam logic [4:0] NORM  = 5'b11010;  // {pcw, ifw, flush, mux, freeze}
  localparam logic [4:0] BRCH  = 5'b11100;
  localparam logic [4:0] STALL = 5'b00000;
  localparam logic [4:0] FRZ   = 5'b00011;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 3) ? 3 : g + 1;
    localparam int CW  = (g == 3) ? 4 : 16;
    logic [CW-1:0] cnt_o;
    hazard_control_unit #(
      .REG_ADDR_W   (5),
      .LOAD_LATENCY (LAT),
      .CNT_W        (CW)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .if_id_rs1      (rs1),
      .if_id_rs2      (rs2),
      .if_id_uses_rs1 (u1),
      .if_id_uses_rs2 (u2),
      .id_ex_rd       (rd),
      .MemRead        (mr),
      .branch_taken   (br),
      .mem_busy       (busy),
      .PC_Write       (o_pcw[g]),
      .If_id_write    (o_ifw[g]),
      .if_id_flush    (o_fl[g]),
      .muxcontrolbit  (o_mux[g]),
      .pipe_freeze    (o_frz[g]),
      .stall_count    (cnt_o)
    );
    assign sc[g] = 16'(cnt_o);
  end

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, busy;
    logic [4:0] exp;
  } vec_t;

  vec_t tv [10];

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int a1, input int a2, input bit e1, input bit e2,
                        input int d, input bit m, input bit b, input bit y);
    rs1 = 5'(a1); rs2 = 5'(a2); u1 = e1; u2 = e2;
    rd = 5'(d); mr = m; br = b; busy = y;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_use();
    set_in(5, 0, 1, 0, 5, 1, 0, 0);
  endtask

  function automatic logic [4:0] ctl(input int g);
    return {o_pcw[g], o_ifw[g], o_fl[g], o_mux[g], o_frz[g]};
  endfunction

  // Called just after a rising edge with inputs set; checks mid-cycle, then
  // advances the model and moves past the next edge.
  task automatic step(input int xg = -1, input logic [4:0] xv = 5'b0);
    logic [4:0] e;
    bit hz;
    #4;
    hz = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    for (int g = 0; g < 4; g++) begin
      if (busy)                  e = FRZ;
      else if (br)               e = BRCH;
      else if (rem[g] > 0 || hz) e = STALL;
      else                       e = NORM;
      check_v($sformatf("ctl%0d", g), 32'(ctl(g)), 32'(e));
      check_v($sformatf("cnt%0d", g), 32'(sc[g]), 32'(mcnt[g]));
      if (g == xg) check_v($sformatf("expect%0d", g), 32'(ctl(g)), 32'(xv));
      if (!busy) begin
        if (br)              rem[g] = 0;
        else if (rem[g] > 0) rem[g]--;
        else if (hz)         rem[g] = mlat[g] - 1;
      end
      if (!e[4] && mcnt[g] < mmax[g]) mcnt[g]++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must return to normal without waiting for a clock.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check_v($sformatf("rst_ctl%0d", g), 32'(ctl(g)), 32'(NORM));
      check_v($sformatf("rst_cnt%0d", g), 32'(sc[g]), 32'd0);
      rem[g]  = 0;
      mcnt[g] = 0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tv[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};   // idle
    tv[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, STALL};  // rs1 load-use
    tv[2] = '{5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, STALL};  // rs2 load-use
    tv[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NORM};   // load to x0
    tv[4] = '{5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NORM};   // rs2 match unused
    tv[5] = '{5'd9, 5'd3, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NORM};   // rs1 match unused
    tv[6] = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NORM};   // not a load
    tv[7] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, BRCH};   // branch beats hazard
    tv[8] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, FRZ};    // busy beats all
    tv[9] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ};    // busy alone

    do_reset();

    // Vector table against the latency-1 instance (never leaves RUN).
    for (int i = 0; i < 10; i++) begin
      set_in(int'(tv[i].rs1), int'(tv[i].rs2), tv[i].u1, tv[i].u2, int'(tv[i].rd),
             tv[i].mr, tv[i].br, tv[i].busy);
      step(0, tv[i].exp);
    end

    // Single load-use, load leaves EX: 1/2/3 bubbles by latency.
    do_reset();
    load_use(); step(2, STALL);
    idle();     step(2, STALL);
    step(2, STALL);
    step(2, NORM);
    check_v("seq_cnt_l1", 32'(sc[0]), 32'd1);
    check_v("seq_cnt_l2", 32'(sc[1]), 32'd2);
    check_v("seq_cnt_l3", 32'(sc[2]), 32'd3);

    // x0 and unused-operand matches over several cycles: no stall at all.
    do_reset();
    set_in(0, 0, 1, 1, 0, 1, 0, 0); step();
    set_in(1, 6, 1, 0, 6, 1, 0, 0); step();
    step(2, NORM);
    check_v("nostall_cnt", 32'(sc[2]), 32'd0);

    // Branch resolved in the second stall cycle cancels remaining bubbles.
    do_reset();
    load_use();             step(2, STALL);
    idle(); br = 1'b1;      step(2, BRCH);
    idle();                 step(2, NORM);
    check_v("br_cnt_l3", 32'(sc[2]), 32'd1);

    // Latency 2 with memory wait after the first bubble.
    do_reset();
    load_use();             step(1, STALL);
    idle(); busy = 1'b1;    step(1, FRZ);
    step(1, FRZ);
    idle();                 step(1, STALL);
    step(1, NORM);
    check_v("busy_cnt_l2", 32'(sc[1]), 32'd4);

    // Saturation of the 4-bit counter.
    do_reset();
    idle(); busy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_v("sat_cnt4", 32'(sc[3]), 32'd15);
    check_v("sat_cnt16", 32'(sc[0]), 32'd20);

    // Reset during LOAD_WAIT aborts the stall at once.
    do_reset();
    load_use(); step();
    idle();
    do_reset();
    step(2, NORM);

    // Randomized traffic with small register space to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
